// File: rtl/display_pkg.sv
// Shared types and the hex-to-7-segment table for the display scanner.
package display_pkg;

   typedef enum logic [1:0] {
      S_BLANK = 2'd0,
      S_SCAN  = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   localparam int unsigned NIBBLE_W  = 4;
   localparam int unsigned SEG_W     = 7;
   localparam logic [0:6]  SEG_BLANK = 7'b1111111;

   // Segments a..g, active-low; bit 0 of the [0:6] vector is segment a.
   function automatic logic [0:6] hex_decode(input logic [3:0] nib);
      logic [0:6] seg;
      unique case (nib)
         4'h0: seg = 7'b0000001;
         4'h1: seg = 7'b1001111;
         4'h2: seg = 7'b0010010;
         4'h3: seg = 7'b0000110;
         4'h4: seg = 7'b1001100;
         4'h5: seg = 7'b0100100;
         4'h6: seg = 7'b0100000;
         4'h7: seg = 7'b0001111;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0001100;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b1100000;
         4'hC: seg = 7'b0110001;
         4'hD: seg = 7'b1000010;
         4'hE: seg = 7'b0110000;
         4'hF: seg = 7'b0111000;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment pattern.
module hex_to_seg7
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [0:6] seg_c
);

   // Table lookup for the currently selected digit.
   always_comb begin
      seg_c = hex_decode(nibble);
   end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex display driver with frame-aligned value updates
// and optional leading-zero blanking.
module hex_display_scanner
   import display_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned SCAN_DIV   = 50000,
   parameter int unsigned BLANK_LZ   = 1
)(
   input  logic                    Clk,
   input  logic                    ResetN,
   input  logic [4*NUM_DIGITS-1:0] Value,
   input  logic                    Load,
   output logic                    Ready,
   output logic [0:6]              Seg,
   output logic [NUM_DIGITS-1:0]   DigitEn,
   output logic                    FrameDone
);

   localparam int unsigned VAL_W = NIBBLE_W * NUM_DIGITS;
   localparam int unsigned PRE_W = $clog2(SCAN_DIV + 1);
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] DIG_OFF  = '1;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [PRE_W-1:0]        pre_q, pre_d;
   logic [VAL_W-1:0]        display_q, display_d;
   logic [VAL_W-1:0]        shadow_q, shadow_d;
   logic                    pending_q, pending_d;
   logic                    ready_q, ready_d;
   logic [0:6]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
   logic                    frame_done_q, frame_done_d;

   logic [3:0]              nibble_c;
   logic [0:6]              seg_dec_c;
   logic                    upper_nz_c;
   logic                    lz_blank_c;

   // Select the nibble of the current digit and see whether it is a leading zero.
   always_comb begin
      nibble_c   = '0;
      upper_nz_c = 1'b0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (idx_q == IDX_W'(i)) begin
            nibble_c = display_q[NIBBLE_W*i +: NIBBLE_W];
         end
         if ((IDX_W'(i) >= idx_q) && (display_q[NIBBLE_W*i +: NIBBLE_W] != 4'd0)) begin
            upper_nz_c = 1'b1;
         end
      end
      lz_blank_c = (BLANK_LZ != 0) && (idx_q != '0) && !upper_nz_c;
   end

   hex_to_seg7 u_hex_to_seg7 (
      .nibble (nibble_c),
      .seg_c  (seg_dec_c)
   );

   // Next-state: load handshake, scan sequencing, frame-boundary commit, output decode.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      pre_d        = pre_q;
      display_d    = display_q;
      shadow_d     = shadow_q;
      pending_d    = pending_q;
      frame_done_d = 1'b0;
      seg_d        = SEG_BLANK;
      digit_en_d   = DIG_OFF;

      // Commits only happen while pending, so they never race an accepted Load.
      if (Load && !pending_q) begin
         shadow_d  = Value;
         pending_d = 1'b1;
      end

      case (state_q)
         S_BLANK: begin
            if (pending_q) begin
               display_d = shadow_q;
               pending_d = 1'b0;
               idx_d     = '0;
               pre_d     = '0;
               state_d   = S_SCAN;
            end
         end
         S_SCAN: begin
            if (pre_q == PRE_LAST) begin
               pre_d   = '0;
               state_d = S_GAP;
            end else begin
               pre_d = pre_q + PRE_W'(1);
            end
         end
         S_GAP: begin
            state_d = S_SCAN;
            if (idx_q == IDX_LAST) begin
               idx_d        = '0;
               frame_done_d = 1'b1;
               if (pending_q) begin
                  display_d = shadow_q;
                  pending_d = 1'b0;
               end
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = S_BLANK;
         end
      endcase

      ready_d = !pending_d;

      if ((state_q == S_SCAN) && !lz_blank_c) begin
         seg_d      = seg_dec_c;
         digit_en_d = ~(NUM_DIGITS'(1) << idx_q);
      end
   end

   // State and output registers.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state_q      <= S_BLANK;
         idx_q        <= '0;
         pre_q        <= '0;
         display_q    <= '0;
         shadow_q     <= '0;
         pending_q    <= 1'b0;
         ready_q      <= 1'b1;
         seg_q        <= SEG_BLANK;
         digit_en_q   <= DIG_OFF;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         pre_q        <= pre_d;
         display_q    <= display_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         ready_q      <= ready_d;
         seg_q        <= seg_d;
         digit_en_q   <= digit_en_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign Ready     = ready_q;
   assign Seg       = seg_q;
   assign DigitEn   = digit_en_q;
   assign FrameDone = frame_done_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner (4 digits, SCAN_DIV=4), with a
// second instance that has leading-zero blanking disabled.
module tb_hex_display_scanner;

   logic        clk;
   logic        rst_n;
   logic [15:0] value;
   logic        load;

   logic        ready,   ready_n;
   logic [0:6]  seg,     seg_n;
   logic [3:0]  den,     den_n;
   logic        fd,      fd_n;

   int n_checks;
   int n_fails;

   localparam logic [27:0] S1234  = {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
   localparam logic [27:0] SFFFF  = {4{7'b0111000}};
   localparam logic [27:0] S5555  = {4{7'b0100100}};
   localparam logic [27:0] S00A0  = {7'b1111111, 7'b1111111, 7'b0001000, 7'b0000001};
   localparam logic [27:0] S00A0N = {7'b0000001, 7'b0000001, 7'b0001000, 7'b0000001};
   localparam logic [27:0] S0000  = {4{7'b0000001}};

   hex_display_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(1)) dut (
      .Clk(clk), .ResetN(rst_n), .Value(value), .Load(load),
      .Ready(ready), .Seg(seg), .DigitEn(den), .FrameDone(fd)
   );

   hex_display_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(0)) dut_nolz (
      .Clk(clk), .ResetN(rst_n), .Value(value), .Load(load),
      .Ready(ready_n), .Seg(seg_n), .DigitEn(den_n), .FrameDone(fd_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts and reports mismatches.
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // All digits dark, no pulse, idle handshake.
   task automatic check_idle(input string tag);
      check_eq({tag, "_main"}, 32'({seg, den, ready, fd}), 32'({7'h7F, 4'hF, 1'b1, 1'b0}));
      check_eq({tag, "_nolz"}, 32'({seg_n, den_n, fd_n}), 32'({7'h7F, 4'hF, 1'b0}));
   endtask

   // Load from S_BLANK; returns at the first displayed cycle of digit 0.
   task automatic load_from_blank(input logic [15:0] v);
      value = v;
      load  = 1'b1;
      @(negedge clk);
      check_eq("ld_rdy_lo", 32'(ready), 32'd0);
      load = 1'b0;
      @(negedge clk);
      check_eq("ld_rdy_hi", 32'(ready), 32'd1);
      check_eq("ld_seg_blank", 32'(seg), 32'h7F);
      @(negedge clk);
   endtask

   // Check one full 20-cycle frame starting at digit 0; optional loads at the start of a digit slot.
   task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] blank,
                              input logic [27:0] segs_n, input int ld1_d, input logic [15:0] ld1_v,
                              input int ld2_d, input logic [15:0] ld2_v);
      logic       pend;
      logic [3:0] e_den, e_den_n;
      logic [6:0] e_seg, e_seg_n;
      pend = 1'b0;
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 5; c++) begin
            load = 1'b0;
            if (d == 3 && c == 4) pend = 1'b0;
            if (c < 4) begin
               e_den   = blank[d] ? 4'hF : 4'(~(4'b0001 << d));
               e_seg   = blank[d] ? 7'h7F : segs[7*d +: 7];
               e_den_n = 4'(~(4'b0001 << d));
               e_seg_n = segs_n[7*d +: 7];
            end else begin
               e_den   = 4'hF;
               e_seg   = 7'h7F;
               e_den_n = 4'hF;
               e_seg_n = 7'h7F;
            end
            check_eq({tag, "_den"}, 32'(den), 32'(e_den));
            check_eq({tag, "_seg"}, 32'(seg), 32'(e_seg));
            check_eq({tag, "_fd"}, 32'(fd), 32'((d == 3 && c == 4) ? 1'b1 : 1'b0));
            check_eq({tag, "_rdy"}, 32'(ready), 32'(!pend));
            check_eq({tag, "_den_nolz"}, 32'(den_n), 32'(e_den_n));
            check_eq({tag, "_seg_nolz"}, 32'(seg_n), 32'(e_seg_n));
            if (c == 0 && d == ld1_d) begin
               value = ld1_v;
               load  = 1'b1;
               pend  = 1'b1;
            end
            if (c == 0 && d == ld2_d) begin
               value = ld2_v;
               load  = 1'b1;
               pend  = 1'b1;
            end
            @(negedge clk);
         end
      end
      load = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      rst_n    = 1'b0;
      load     = 1'b0;
      value    = 16'h0000;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst_n = 1'b1;

      // Idle after reset: nothing lights, no frame pulses.
      repeat (40) begin
         @(negedge clk);
         check_idle("idle");
      end

      // Normal scan, then a mid-frame update, then a dropped second load.
      load_from_blank(16'h1234);
      check_frame("f1234a", S1234, 4'b0000, S1234, -1, 16'h0, -1, 16'h0);
      check_frame("f1234b", S1234, 4'b0000, S1234, 1, 16'hFFFF, -1, 16'h0);
      check_frame("fffff", SFFFF, 4'b0000, SFFFF, 0, 16'h5555, 2, 16'h6666);
      check_frame("f5555", S5555, 4'b0000, S5555, -1, 16'h0, -1, 16'h0);

      // Asynchronous reset in the middle of a digit slot.
      @(negedge clk);
      check_eq("pre_rst_seg", 32'(seg), 32'(7'b0100100));
      check_eq("pre_rst_den", 32'(den), 32'(4'b1110));
      #2 rst_n = 1'b0;
      #1 check_idle("rst_async");
      @(negedge clk);
      check_idle("rst_hold");
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check_idle("post_rst");
      end

      // Leading-zero blanking, including the all-zero value.
      load_from_blank(16'h00A0);
      check_frame("f00a0", S00A0, 4'b1100, S00A0N, 1, 16'h0000, -1, 16'h0);
      check_frame("f0000", S0000, 4'b1110, S0000, -1, 16'h0, -1, 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
